// File: rtl/equiv_checker.sv
// Exhaustive equivalence checker: sweeps every N_IN-bit vector, compares a reference
// function against a candidate, counts mismatches and captures the first failing vector.
module equiv_checker #(
    parameter int N_IN        = 3,
    parameter int N_OUT       = 1,
    parameter int SETTLE      = 1,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec,
    input  logic [N_OUT-1:0]  ref_out,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_vld
);

    localparam int              CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST   = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic             mis;
    logic             last_vec;
    logic             stop_now;
    logic [N_IN:0]    err_next;

    // Sample-edge decision; only consumed when cnt has run down to zero in RUN.
    always_comb begin
        mis      = (ref_out != dut_out);
        err_next = err_count + {{N_IN{1'b0}}, mis};
        last_vec = (vec == VEC_LAST);
        stop_now = last_vec || ((STOP_ON_ERR != 0) && mis);
    end

    // NOTE: state uses non-blocking assignments so every register updates from
    // the pre-edge values; blocking here would let later statements see new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            vec           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        cnt           <= CNT_RELOAD;
                        vec           <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_vec <= '0;
                        first_err_vld <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        err_count <= err_next;
                        if (mis && !first_err_vld) begin
                            first_err_vec <= vec;
                            first_err_vld <= 1'b1;
                        end
                        // vec is held on the final vector so it never wraps.
                        if (stop_now) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            vec <= vec + 1'b1;
                            cnt <= CNT_RELOAD;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_checker.sv
// Self-checking bench for equiv_checker: three instances cover the full sweep,
// stop-on-error and multi-cycle settle configurations.
module tb_equiv_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: N_IN=3, SETTLE=1, full sweep
    logic       start_a;
    logic [1:0] mode_a;
    logic [2:0] vec_a;
    logic       ref_a, dut_a, busy_a, done_a, pass_a, vld_a;
    logic [3:0] err_a;
    logic [2:0] fev_a;

    // Instance B: N_IN=3, SETTLE=1, STOP_ON_ERR=1
    logic       start_b;
    logic [2:0] vec_b;
    logic       ref_b, dut_b, busy_b, done_b, pass_b, vld_b;
    logic [3:0] err_b;
    logic [2:0] fev_b;

    // Instance C: N_IN=4, SETTLE=3, candidate is the complement
    logic       start_c;
    logic [3:0] vec_c;
    logic       ref_c, dut_c, busy_c, done_c, pass_c, vld_c;
    logic [4:0] err_c;
    logic [3:0] fev_c;

    // Reference f in POS form and an equivalent SOP: a ? c : b
    function automatic logic f3_pos(input logic [2:0] v);
        return (v[2] | v[1]) & (~v[2] | v[0]);
    endfunction

    function automatic logic f3_sop(input logic [2:0] v);
        return (v[2] & v[0]) | (~v[2] & v[1]);
    endfunction

    function automatic logic f4_pos(input logic [3:0] v);
        return (v[3] | v[2] | ~v[1]) & (v[1] | v[0]);
    endfunction

    assign ref_a = f3_pos(vec_a);
    always_comb begin
        dut_a = f3_sop(vec_a);
        case (mode_a)
            2'd1:    dut_a = f3_sop(vec_a) ^ (vec_a == 3'd5);
            2'd2:    dut_a = ~f3_sop(vec_a);
            2'd3:    dut_a = f3_sop(vec_a) ^ (vec_a == 3'd7);
            default: dut_a = f3_sop(vec_a);
        endcase
    end

    assign ref_b = f3_pos(vec_b);
    assign dut_b = f3_sop(vec_b) ^ ((vec_b == 3'd2) || (vec_b == 3'd6));

    assign ref_c = f4_pos(vec_c);
    assign dut_c = ~f4_pos(vec_c);

    equiv_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1), .STOP_ON_ERR(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a),
        .ref_out(ref_a), .dut_out(dut_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_vec(fev_a), .first_err_vld(vld_a)
    );

    equiv_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1), .STOP_ON_ERR(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b),
        .ref_out(ref_b), .dut_out(dut_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_vec(fev_b), .first_err_vld(vld_b)
    );

    equiv_checker #(.N_IN(4), .N_OUT(1), .SETTLE(3), .STOP_ON_ERR(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .vec(vec_c),
        .ref_out(ref_c), .dut_out(dut_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .first_err_vec(fev_c), .first_err_vld(vld_c)
    );

    typedef struct packed {
        logic [3:0] vec;
        logic       busy;
        logic       done;
        logic       pass;
        logic [4:0] err;
        logic [3:0] fev;
        logic       vld;
    } snap_t;

    typedef struct {
        logic [1:0] mode;
        int         exp_edges;
        logic [4:0] exp_err;
        logic [3:0] exp_fev;
        logic       exp_vld;
        logic       exp_pass;
    } vec_t;

    function automatic snap_t get_snap(input int which);
        snap_t s;
        s = '0;
        case (which)
            0: begin
                s.vec = {1'b0, vec_a}; s.busy = busy_a; s.done = done_a; s.pass = pass_a;
                s.err = {1'b0, err_a}; s.fev = {1'b0, fev_a}; s.vld = vld_a;
            end
            1: begin
                s.vec = {1'b0, vec_b}; s.busy = busy_b; s.done = done_b; s.pass = pass_b;
                s.err = {1'b0, err_b}; s.fev = {1'b0, fev_b}; s.vld = vld_b;
            end
            default: begin
                s.vec = vec_c; s.busy = busy_c; s.done = done_c; s.pass = pass_c;
                s.err = err_c; s.fev = fev_c; s.vld = vld_c;
            end
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_start(input int which, input logic val);
        case (which)
            0:       start_a = val;
            1:       start_b = val;
            default: start_c = val;
        endcase
    endtask

    // Pulses start for one cycle, then follows the sweep edge by edge until done.
    // Optionally re-pulses start while busy on vector restart_vec.
    task automatic sweep(input int which, input int settle, input int exp_edges,
                         input int restart_vec, input string tag);
        snap_t s;
        snap_t s_start;
        int    edges;
        bit    seq_ok;
        bit    pulsed;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
        s = get_snap(which);
        s_start = '0;
        s_start.busy = 1'b1;
        check({tag, " start_state"}, s, s_start);
        edges  = 0;
        seq_ok = 1'b1;
        pulsed = 1'b0;
        while (!s.done && edges < 1000) begin
            if (!s.busy || s.vec != 4'(edges / settle)) seq_ok = 1'b0;
            if (restart_vec >= 0 && !pulsed && s.vec == 4'(restart_vec)) begin
                set_start(which, 1'b1);
                pulsed = 1'b1;
            end
            @(posedge clk);
            #1;
            set_start(which, 1'b0);
            edges++;
            s = get_snap(which);
        end
        check({tag, " vec_sequence"}, seq_ok, 1'b1);
        check({tag, " done_edges"}, edges, exp_edges);
        check({tag, " busy_low"}, s.busy, 1'b0);
    endtask

    task automatic check_results(input int which, input vec_t t, input string tag);
        snap_t s;
        s = get_snap(which);
        check({tag, " done"}, s.done, 1'b1);
        check({tag, " err_count"}, s.err, t.exp_err);
        check({tag, " first_err_vld"}, s.vld, t.exp_vld);
        if (t.exp_vld) check({tag, " first_err_vec"}, s.fev, t.exp_fev);
        check({tag, " pass"}, s.pass, t.exp_pass);
    endtask

    vec_t tbl[4];

    initial begin
        snap_t s;
        vec_t  t;
        int    guard;

        tbl[0] = '{mode: 2'd0, exp_edges: 8, exp_err: 5'd0, exp_fev: 4'd0, exp_vld: 1'b0, exp_pass: 1'b1};
        tbl[1] = '{mode: 2'd1, exp_edges: 8, exp_err: 5'd1, exp_fev: 4'd5, exp_vld: 1'b1, exp_pass: 1'b0};
        tbl[2] = '{mode: 2'd2, exp_edges: 8, exp_err: 5'd8, exp_fev: 4'd0, exp_vld: 1'b1, exp_pass: 1'b0};
        tbl[3] = '{mode: 2'd3, exp_edges: 8, exp_err: 5'd1, exp_fev: 4'd7, exp_vld: 1'b1, exp_pass: 1'b0};

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        mode_a  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_state inst%0d", i), get_snap(i), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full 8-vector sweeps on instance A with different candidates.
        for (int i = 0; i < 4; i++) begin
            mode_a = tbl[i].mode;
            sweep(0, 1, tbl[i].exp_edges, -1, $sformatf("tbl%0d", i));
            check_results(0, tbl[i], $sformatf("tbl%0d", i));
        end

        // Stop-on-error: mismatches at 2 and 6, halts after vector 2.
        t = '{mode: 2'd0, exp_edges: 3, exp_err: 5'd1, exp_fev: 4'd2, exp_vld: 1'b1, exp_pass: 1'b0};
        sweep(1, 1, 3, -1, "stop_on_err");
        check_results(1, t, "stop_on_err");
        check("stop_on_err vec_held", get_snap(1).vec, 4'd2);

        // SETTLE=3, N_IN=4, every vector mismatches: count reaches 2**N_IN.
        t = '{mode: 2'd0, exp_edges: 48, exp_err: 5'd16, exp_fev: 4'd0, exp_vld: 1'b1, exp_pass: 1'b0};
        sweep(2, 3, 48, -1, "settle3");
        check_results(2, t, "settle3");
        check("settle3 vec_held_last", get_snap(2).vec, 4'd15);

        // Asynchronous reset in the middle of a sweep.
        mode_a = 2'd0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        guard = 0;
        while (vec_a != 3'd4 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rst_mid reached_vec4", vec_a, 3'd4);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid async_clear", get_snap(0), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid stays_idle", get_snap(0), 0);
        sweep(0, 1, 8, -1, "after_rst");
        check_results(0, tbl[0], "after_rst");

        // start while busy is ignored; start in DONE restarts and clears results.
        mode_a = 2'd1;
        sweep(0, 1, 8, 3, "restart_busy");
        check_results(0, tbl[1], "restart_busy");
        mode_a = 2'd0;
        sweep(0, 1, 8, -1, "restart_done");
        check_results(0, tbl[0], "restart_done");

        // Done is held while start stays low.
        repeat (3) @(posedge clk);
        #1;
        s = get_snap(0);
        check("done_held", s.done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
